// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the pixel row streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_pkg;

  localparam int PIX_W    = 10;
  localparam int ROW_PIX  = 28;
  localparam int NUM_ROWS = 28;
  localparam int SEL_BIT  = 5;
  localparam int COL_W    = 5;
  localparam int ROW_W    = PIX_W * ROW_PIX;

  // Terminal counter values, sized to the counters so compares are exact-width.
  localparam logic [SEL_BIT-1:0] LAST_ROW = SEL_BIT'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]   LAST_COL = COL_W'(ROW_PIX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_row_streamer.sv
// Walks rows 0..NUM_ROWS-1 on row_sel, latches each row and streams its pixels one per beat.
// Latency: first pixel valid 2 cycles after start; one LOAD bubble per row; done 2 cycles after last beat.
// Backpressure: pix_ready low holds pix_valid and all pix_* fields stable; nothing is dropped.
module pixel_row_streamer
  import pixel_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SEL_BIT-1:0] row_sel,
  input  logic [ROW_W-1:0]   row_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [SEL_BIT-1:0] pix_row,
  output logic [COL_W-1:0]   pix_col,
  output logic               pix_last,
  output logic               busy,
  output logic               done
);

  state_t           state;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col;

  // Frame sequencer: state, row/column counters, row latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_sel   <= '0;
      row_reg   <= '0;
      col       <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_sel <= '0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // row_data has had a full cycle to settle for the current row_sel.
          row_reg   <= row_data;
          col       <= '0;
          pix_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (pix_ready) begin
            if (col != LAST_COL) begin
              col <= col + COL_W'(1);
            end else begin
              pix_valid <= 1'b0;
              if (row_sel != LAST_ROW) begin
                row_sel <= row_sel + SEL_BIT'(1);
                state   <= LOAD;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          row_sel <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel fields are pure functions of registers, so they cannot move while stalled.
  always_comb begin
    pix_data = row_reg[int'(col) * PIX_W +: PIX_W];
    pix_row  = row_sel;
    pix_col  = col;
    pix_last = pix_valid && (row_sel == LAST_ROW) && (col == LAST_COL);
  end

endmodule
